// File: rtl/memory_access_sequencer_pkg.sv
// memory_access_sequencer_pkg: shared types and decode helpers for the load/store sequencer
package memory_access_sequencer_pkg;
  typedef enum logic [1:0] {MM_NOP, MM_LOAD, MM_STORE_PRELOAD, MM_STORE} MemoryMode_t;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } Funct3_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRELOAD, S_STORE, S_HALT} SequencerState_t;
  function automatic logic legal_load(input logic [2:0] f);
    return f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
  function automatic logic legal_store(input logic [2:0] f);
    return f inside {F3_B, F3_H, F3_W};
  endfunction
endpackage

// File: rtl/memory_access_sequencer_if.sv
// memory_access_sequencer_if: request/controller bus between control unit, memory controller and sequencer
// master: drives start/isLoad/isStore/funct3/offset/rs2/preloadWord/unalignedAccess
// slave: drives memoryMode/storeData/busy/done/error
interface memory_access_sequencer_if;
  import memory_access_sequencer_pkg::*;
  logic start;
  logic isLoad;
  logic isStore;
  logic [2:0] funct3;
  logic [1:0] offset;
  logic [31:0] rs2;
  logic [31:0] preloadWord;
  logic unalignedAccess;
  MemoryMode_t memoryMode;
  logic [31:0] storeData;
  logic busy;
  logic done;
  logic error;
  modport master (
    output start, isLoad, isStore, funct3, offset, rs2, preloadWord, unalignedAccess,
    input memoryMode, storeData, busy, done, error
  );
  modport slave (
    input start, isLoad, isStore, funct3, offset, rs2, preloadWord, unalignedAccess,
    output memoryMode, storeData, busy, done, error
  );
endinterface

// File: rtl/memory_access_sequencer_store_data_merger.sv
// store_data_merger: combinational read-modify-write merge of rs2 into a preloaded word
// in: preloadWord, rs2, funct3 (sb/sh/sw), offset; out: mergedWord
module store_data_merger
  import memory_access_sequencer_pkg::*;
(
  input  logic [31:0] preloadWord,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] mergedWord
);
  logic [3:0] be;
  logic [31:0] wdata;
  assign be = funct3 == F3_W ? 4'hf : funct3 == F3_H ? (offset[1] ? 4'hc : 4'h3) : 4'b0001 << offset;
  assign wdata = funct3 == F3_W ? rs2 : funct3 == F3_H ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
  genvar b;
  for (b = 0; b < 4; b++) begin : g_byte
    assign mergedWord[8*b +: 8] = be[b] ? wdata[8*b +: 8] : preloadWord[8*b +: 8];
  end
endmodule

// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer: sequences one load/store into NOP/LOAD/STORE_PRELOAD/STORE for the memory controller
// clock, reset (sync, active-low); bus: slave side of memory_access_sequencer_if
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
(
  input logic clock,
  input logic reset,
  memory_access_sequencer_if.slave bus
);
  SequencerState_t state_q, state_d;
  logic [2:0] funct3_q, funct3_d;
  logic [31:0] rs2_q, rs2_d, merge_q, merge_d, merged;
  logic error_q, error_d;
  logic accept, load_ok, store_ok;
  assign accept = state_q == S_IDLE && bus.start;
  assign load_ok = bus.isLoad && !bus.isStore && legal_load(bus.funct3);
  assign store_ok = bus.isStore && !bus.isLoad && legal_store(bus.funct3);
  store_data_merger u_merger (
    .preloadWord(bus.preloadWord),
    .rs2(rs2_q),
    .funct3(funct3_q),
    .offset(bus.offset),
    .mergedWord(merged)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      funct3_q <= '0;
      rs2_q <= '0;
      merge_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      funct3_q <= funct3_d;
      rs2_q <= rs2_d;
      merge_q <= merge_d;
      error_q <= error_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = !bus.start ? S_IDLE : load_ok ? S_LOAD : store_ok ? S_PRELOAD : S_HALT;
      S_LOAD:    state_d = bus.unalignedAccess ? S_HALT : S_IDLE;
      S_PRELOAD: state_d = bus.unalignedAccess ? S_HALT : S_STORE;
      S_STORE:   state_d = bus.unalignedAccess ? S_HALT : S_IDLE;
      default:   state_d = S_HALT;
    endcase
    funct3_d = accept ? bus.funct3 : funct3_q;
    rs2_d = accept ? bus.rs2 : rs2_q;
    merge_d = state_q == S_PRELOAD ? merged : merge_q;
    error_d = error_q || state_d == S_HALT;
  end
  // a mid-sequence misalignment in STORE suppresses the write, not just the done pulse
  always_comb begin
    bus.busy = state_q != S_IDLE;
    bus.done = (state_q == S_LOAD || state_q == S_STORE) && !bus.unalignedAccess;
    bus.memoryMode = state_q == S_LOAD ? MM_LOAD :
                     state_q == S_PRELOAD ? MM_STORE_PRELOAD :
                     state_q == S_STORE && !bus.unalignedAccess ? MM_STORE : MM_NOP;
    bus.storeData = merge_q;
    bus.error = error_q;
  end
endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb_memory_access_sequencer: scoreboard bench with directed and random load/store sequences
module tb_memory_access_sequencer;
  import memory_access_sequencer_pkg::*;
  typedef enum int {K_LOAD, K_STORE, K_HALT, K_BAD} kind_t;
  typedef struct {kind_t kind; logic [31:0] data;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  bit err_prev = 1'b0;
  kind_t obs;
  exp_t mon_e;
  logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  always #5 clock = ~clock;
  memory_access_sequencer_if bus();
  memory_access_sequencer dut (.clock(clock), .reset(reset), .bus(bus.slave));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic exp_t model(input bit il, input bit is, input logic [2:0] f3, input logic [1:0] off,
                                 input logic [31:0] r2, input logic [31:0] pw, input bit uap, input bit uas);
    exp_t e;
    logic [7:0] b[4];
    e.data = '0;
    if (il && !is && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) e.kind = uap ? K_HALT : K_LOAD;
    else if (is && !il && f3 inside {3'd0, 3'd1, 3'd2}) begin
      if (uap || uas) e.kind = K_HALT;
      else begin
        e.kind = K_STORE;
        for (int k = 0; k < 4; k++) b[k] = pw[8*k +: 8];
        if (f3 == 3'd0) b[off] = r2[7:0];
        else if (f3 == 3'd1) begin
          b[{off[1], 1'b0}] = r2[7:0];
          b[{off[1], 1'b1}] = r2[15:8];
        end else for (int k = 0; k < 4; k++) b[k] = r2[8*k +: 8];
        e.data = {b[3], b[2], b[1], b[0]};
      end
    end else e.kind = K_HALT;
    return e;
  endfunction
  always @(negedge clock) begin
    if (bus.done || (bus.error && !err_prev) || bus.memoryMode == MM_STORE) begin
      obs = bus.error ? K_HALT :
            (bus.done && bus.memoryMode == MM_LOAD) ? K_LOAD :
            (bus.done && bus.memoryMode == MM_STORE) ? K_STORE : K_BAD;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got kind %0d expected no event at %0t", obs, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("kind", 32'(obs), 32'(mon_e.kind));
        if (mon_e.kind == K_STORE) check("storeData", bus.storeData, mon_e.data);
      end
    end
    err_prev = bus.error;
  end
  task automatic check_reset_state(input string tag);
    check({tag, "_mode"}, 32'(bus.memoryMode), 32'(MM_NOP));
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_error"}, 32'(bus.error), 0);
    check({tag, "_storeData"}, bus.storeData, 0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    check_reset_state("reset");
    reset = 1'b1;
  endtask
  task automatic run_txn(input bit il, input bit is, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] r2, input logic [31:0] pw, input bit uap, input bit uas);
    exp_t e;
    int n;
    e = model(il, is, f3, off, r2, pw, uap, uas);
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.isLoad = il;
    bus.isStore = is;
    bus.funct3 = f3;
    bus.offset = off;
    bus.rs2 = r2;
    bus.preloadWord = pw;
    bus.unalignedAccess = uap;
    tick();
    bus.start = 1'($urandom_range(0, 1));
    bus.isLoad = 1'($urandom_range(0, 1));
    bus.isStore = 1'($urandom_range(0, 1));
    bus.funct3 = 3'($urandom_range(0, 7));
    bus.rs2 = $urandom;
    tick();
    bus.start = 1'b0;
    bus.unalignedAccess = uas;
    tick();
    bus.unalignedAccess = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: %0d responses still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    if (e.kind == K_HALT) begin
      check("halt_busy", 32'(bus.busy), 1);
      check("halt_mode", 32'(bus.memoryMode), 32'(MM_NOP));
      check("halt_error", 32'(bus.error), 1);
      do_reset();
    end else check("idle_busy", 32'(bus.busy), 0);
  endtask
  task automatic mid_reset();
    bus.start = 1'b1;
    bus.isLoad = 1'b0;
    bus.isStore = 1'b1;
    bus.funct3 = 3'd2;
    bus.offset = 2'd0;
    bus.rs2 = $urandom;
    bus.preloadWord = $urandom;
    bus.unalignedAccess = 1'b0;
    tick();
    bus.start = 1'b0;
    check("preload_mode", 32'(bus.memoryMode), 32'(MM_STORE_PRELOAD));
    reset = 1'b0;
    tick();
    check_reset_state("midreset");
    reset = 1'b1;
    repeat (3) tick();
  endtask
  function automatic bit misaligned(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'd1 ? off[0] : f3[1:0] == 2'd2 ? off != 2'd0 : 1'b0;
  endfunction
  initial begin
    bit il, is, uap, uas;
    logic [2:0] f3;
    logic [1:0] off;
    int r;
    bus.start = 1'b0;
    bus.isLoad = 1'b0;
    bus.isStore = 1'b0;
    bus.funct3 = '0;
    bus.offset = '0;
    bus.rs2 = '0;
    bus.preloadWord = '0;
    bus.unalignedAccess = 1'b0;
    tick();
    do_reset();
    run_txn(1, 0, 3'b010, 2'd0, $urandom, $urandom, 0, 0);
    run_txn(0, 1, 3'b000, 2'd2, 32'h0000_00ab, 32'h1122_3344, 0, 0);
    run_txn(0, 1, 3'b001, 2'd2, 32'h0000_beef, 32'h1122_3344, 0, 0);
    run_txn(0, 1, 3'b001, 2'd0, 32'hcafe_beef, 32'h1122_3344, 0, 0);
    run_txn(0, 1, 3'b010, 2'd0, 32'hdead_beef, 32'h1122_3344, 0, 0);
    run_txn(0, 1, 3'b010, 2'd1, $urandom, $urandom, 1, 0);
    run_txn(0, 1, 3'b011, 2'd0, $urandom, $urandom, 0, 0);
    run_txn(1, 1, 3'b010, 2'd0, $urandom, $urandom, 0, 0);
    run_txn(0, 0, 3'b010, 2'd0, $urandom, $urandom, 0, 0);
    run_txn(1, 0, 3'b001, 2'd1, $urandom, $urandom, 1, 0);
    run_txn(0, 1, 3'b000, 2'd3, $urandom, $urandom, 0, 1);
    run_txn(1, 0, 3'b110, 2'd0, $urandom, $urandom, 0, 0);
    mid_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      il = r < 4 || r == 8;
      is = (r >= 4 && r < 8) || r == 8;
      f3 = $urandom_range(0, 9) < 8 ? (is ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)])
                                    : 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      uap = misaligned(f3, off) || $urandom_range(0, 15) == 0;
      uas = $urandom_range(0, 7) == 0;
      run_txn(il, is, f3, off, $urandom, $urandom, uap, uas);
      if (i % 50 == 0) mid_reset();
    end
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
